// File: rtl/sa_share_arbiter.sv
// rtl/sa_share_arbiter.sv - round-robin owner arbiter muxing N_REQ engines onto one shared systolic array
// Optional watchdog release enabled by defining SA_ARB_TIMEOUT_EN.
module sa_share_arbiter #(
    parameter int D_W    = 8,
    parameter int SA_R   = 16,
    parameter int SA_C   = 16,
    parameter int K_DIM  = 128,
    parameter int N_REQ  = 4,
    parameter int TO_CYC = 4096
) (
    input  logic                                              I_CLK,
    input  logic                                              I_SYNC_RSTN,
    input  logic [N_REQ-1:0]                                  I_REQ,
    input  logic [N_REQ-1:0]                                  I_REQ_START,
    input  logic [N_REQ-1:0]                                  I_REQ_CLEARN,
    input  logic [N_REQ-1:0][SA_R-1:0][K_DIM-1:0][D_W-1:0]    I_REQ_MAT_1,
    input  logic [N_REQ-1:0][K_DIM-1:0][SA_C-1:0][D_W-1:0]    I_REQ_MAT_2,
    output logic [N_REQ-1:0]                                  O_GNT,
    output logic [$clog2(N_REQ)-1:0]                          O_GNT_IDX,
    output logic                                              O_BUSY,
    output logic [N_REQ-1:0]                                  O_REQ_VLD,
    output logic                                              O_SA_START,
    output logic                                              O_SA_CLEARN,
    output logic [SA_R-1:0][K_DIM-1:0][D_W-1:0]               O_MAT_1,
    output logic [K_DIM-1:0][SA_C-1:0][D_W-1:0]               O_MAT_2,
    input  logic                                              I_SA_VLD,
    input  logic [SA_R-1:0][SA_C-1:0][D_W-1:0]                I_SA_RESULT,
    output logic [SA_R-1:0][SA_C-1:0][D_W-1:0]                O_SA_RESULT,
    output logic                                              O_TIMEOUT
);

    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] ptr_after_owner;
    logic [IDX_W:0]   cand;
    logic             win_vld;
    logic             timeout_hit;
    logic             drop;

    // Scan from highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_REQ)) begin
                cand = cand - (IDX_W+1)'(N_REQ);
            end
            if (I_REQ[cand[IDX_W-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[IDX_W-1:0];
            end
        end
    end

    assign ptr_after_owner = (O_GNT_IDX == IDX_W'(N_REQ - 1)) ? '0 : O_GNT_IDX + IDX_W'(1);
    assign drop            = (state == S_GRANT) && (!I_REQ[O_GNT_IDX] || timeout_hit);

`ifdef SA_ARB_TIMEOUT_EN
    localparam int WD_W = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;

    logic [WD_W-1:0] wd_cnt;
    logic            timeout_q;

    assign timeout_hit = (state == S_GRANT) && !I_SA_VLD && (wd_cnt == WD_W'(TO_CYC - 1));
    assign O_TIMEOUT   = timeout_q;

    always_ff @(posedge I_CLK) begin
        if (!I_SYNC_RSTN) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
            if (state != S_GRANT || I_SA_VLD || timeout_hit) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign O_TIMEOUT   = 1'b0;
`endif

    always_ff @(posedge I_CLK) begin
        if (!I_SYNC_RSTN) begin
            state     <= S_IDLE;
            O_GNT     <= '0;
            O_GNT_IDX <= '0;
            O_BUSY    <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && win_vld) begin
                O_GNT     <= N_REQ'(1) << win_idx;
                O_GNT_IDX <= win_idx;
                O_BUSY    <= 1'b1;
            end else if (drop) begin
                O_GNT  <= '0;
                O_BUSY <= 1'b0;
                rr_ptr <= ptr_after_owner;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (win_vld) state_nxt = S_GRANT;
            S_GRANT:   if (drop) state_nxt = S_RELEASE;
            S_RELEASE: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Only the registered owner ever drives the SA; the release cycle clears it.
    always_comb begin
        O_MAT_1     = '0;
        O_MAT_2     = '0;
        O_SA_START  = 1'b0;
        O_SA_CLEARN = 1'b1;
        O_REQ_VLD   = '0;
        case (state)
            S_GRANT: begin
                O_MAT_1     = I_REQ_MAT_1[O_GNT_IDX];
                O_MAT_2     = I_REQ_MAT_2[O_GNT_IDX];
                O_SA_START  = I_REQ_START[O_GNT_IDX];
                O_SA_CLEARN = I_REQ_CLEARN[O_GNT_IDX];
                O_REQ_VLD   = O_GNT & {N_REQ{I_SA_VLD}};
            end
            S_RELEASE: O_SA_CLEARN = 1'b0;
            default: ;
        endcase
    end

    assign O_SA_RESULT = I_SA_RESULT;

endmodule

// File: tb/tb_sa_share_arbiter.sv
// tb/tb_sa_share_arbiter.sv - randomized and directed checks of sa_share_arbiter against an ownership model
module tb_sa_share_arbiter;

    localparam int D_W    = 8;
    localparam int SA_R   = 2;
    localparam int SA_C   = 2;
    localparam int K_DIM  = 4;
    localparam int N_REQ  = 4;
    localparam int TO_CYC = 16;
    localparam int IDX_W  = $clog2(N_REQ);

    logic                                           clk;
    logic                                           rstn;
    logic [N_REQ-1:0]                               req;
    logic [N_REQ-1:0]                               req_start;
    logic [N_REQ-1:0]                               req_clearn;
    logic [N_REQ-1:0][SA_R-1:0][K_DIM-1:0][D_W-1:0] req_mat_1;
    logic [N_REQ-1:0][K_DIM-1:0][SA_C-1:0][D_W-1:0] req_mat_2;
    logic [N_REQ-1:0]                               o_gnt;
    logic [IDX_W-1:0]                               o_gnt_idx;
    logic                                           o_busy;
    logic [N_REQ-1:0]                               o_req_vld;
    logic                                           o_sa_start;
    logic                                           o_sa_clearn;
    logic [SA_R-1:0][K_DIM-1:0][D_W-1:0]            o_mat_1;
    logic [K_DIM-1:0][SA_C-1:0][D_W-1:0]            o_mat_2;
    logic                                           sa_vld;
    logic [SA_R-1:0][SA_C-1:0][D_W-1:0]             sa_result;
    logic [SA_R-1:0][SA_C-1:0][D_W-1:0]             o_sa_result;
    logic                                           o_timeout;

    sa_share_arbiter #(
        .D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .K_DIM(K_DIM), .N_REQ(N_REQ), .TO_CYC(TO_CYC)
    ) dut (
        .I_CLK(clk),
        .I_SYNC_RSTN(rstn),
        .I_REQ(req),
        .I_REQ_START(req_start),
        .I_REQ_CLEARN(req_clearn),
        .I_REQ_MAT_1(req_mat_1),
        .I_REQ_MAT_2(req_mat_2),
        .O_GNT(o_gnt),
        .O_GNT_IDX(o_gnt_idx),
        .O_BUSY(o_busy),
        .O_REQ_VLD(o_req_vld),
        .O_SA_START(o_sa_start),
        .O_SA_CLEARN(o_sa_clearn),
        .O_MAT_1(o_mat_1),
        .O_MAT_2(o_mat_2),
        .I_SA_VLD(sa_vld),
        .I_SA_RESULT(sa_result),
        .O_SA_RESULT(o_sa_result),
        .O_TIMEOUT(o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Ownership model: who holds the SA, whether a release cycle is in progress,
    // where the next search starts, and how long the owner has gone without valid.
    int m_owner   = -1;
    bit m_rel     = 1'b0;
    int m_ptr     = 0;
    int m_idle    = 0;
    bit m_tout    = 1'b0;
    bit m_started = 1'b0;
`ifdef SA_ARB_TIMEOUT_EN
    localparam bit TOUT_EN = 1'b1;
`else
    localparam bit TOUT_EN = 1'b0;
`endif

    always @(posedge clk) begin
        if (!rstn) begin
            m_owner = -1; m_rel = 1'b0; m_ptr = 0; m_idle = 0; m_tout = 1'b0;
            m_started = 1'b1;
        end else begin
            m_tout = 1'b0;
            if (m_rel) begin
                m_rel = 1'b0;
            end else if (m_owner < 0) begin
                for (int k = 0; k < N_REQ; k++) begin
                    if (m_owner < 0 && req[(m_ptr + k) % N_REQ]) begin
                        m_owner = (m_ptr + k) % N_REQ;
                        m_idle  = 0;
                    end
                end
            end else begin
                if (!req[m_owner] || (TOUT_EN && !sa_vld && m_idle >= TO_CYC - 1)) begin
                    m_tout  = req[m_owner];
                    m_ptr   = (m_owner + 1) % N_REQ;
                    m_owner = -1;
                    m_rel   = 1'b1;
                end else begin
                    m_idle = sa_vld ? 0 : m_idle + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            logic [63:0] e_m1, e_m2;
            e_m1 = '0;
            e_m2 = '0;
            if (m_owner >= 0) begin
                e_m1 = 64'(req_mat_1[m_owner]);
                e_m2 = 64'(req_mat_2[m_owner]);
            end
            chk("gnt",    64'(o_gnt),  (m_owner >= 0) ? (64'd1 << m_owner) : 64'd0);
            chk("busy",   64'(o_busy), 64'(m_owner >= 0));
            if (m_owner >= 0) chk("gnt_idx", 64'(o_gnt_idx), 64'(m_owner));
            chk("req_vld", 64'(o_req_vld), (m_owner >= 0 && sa_vld) ? (64'd1 << m_owner) : 64'd0);
            chk("sa_start", 64'(o_sa_start), (m_owner >= 0) ? 64'(req_start[m_owner]) : 64'd0);
            chk("sa_clearn", 64'(o_sa_clearn),
                (m_owner >= 0) ? 64'(req_clearn[m_owner]) : (m_rel ? 64'd0 : 64'd1));
            chk("mat_1", 64'(o_mat_1), e_m1);
            chk("mat_2", 64'(o_mat_2), e_m2);
            chk("sa_result", 64'(o_sa_result), 64'(sa_result));
            chk("timeout", 64'(o_timeout), 64'(m_tout && TOUT_EN));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_gnt(output int idx);
        int n = 0;
        while (!o_busy && n < 20) begin
            cyc();
            n++;
        end
        chk("wait_gnt", 64'(o_busy), 64'd1);
        idx = int'(o_gnt_idx);
    endtask

    task automatic rand_mats();
        for (int i = 0; i < N_REQ; i++) begin
            req_mat_1[i] = {$urandom, $urandom};
            req_mat_2[i] = {$urandom, $urandom};
        end
        sa_result = $urandom;
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};
    int idx;
    int n;

    initial begin
        rstn = 1'b0; req = '0; req_start = '0; req_clearn = '1; sa_vld = 1'b0;
        rand_mats();
        idle(3);
        chk("rst_gnt",    64'(o_gnt),       64'd0);
        chk("rst_clearn", 64'(o_sa_clearn), 64'd1);
        chk("rst_start",  64'(o_sa_start),  64'd0);
        chk("rst_mat_1",  64'(o_mat_1),     64'd0);
        rstn = 1'b1;
        cyc();

        // round-robin order with one release cycle per handover
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_gnt(idx);
            chk("rr_order", 64'(idx), 64'(exp_order[g]));
            sa_vld = 1'b1;
            cyc();
            sa_vld = 1'b0;
            req[idx] = 1'b0;
            cyc();
            chk("handover_gnt",    64'(o_gnt),       64'd0);
            chk("handover_clearn", 64'(o_sa_clearn), 64'd0);
            req[idx] = 1'b1;
            cyc();
        end
        req = '0;
        idle(4);

        // single requester, operand and valid routing
        req_mat_1[2][0][0] = 8'h5A;
        req = 4'b0100;
        cyc();
        chk("t2_gnt",     64'(o_gnt),          64'b0100);
        chk("t2_idx",     64'(o_gnt_idx),      64'd2);
        chk("t2_mat",     64'(o_mat_1[0][0]),  64'h5A);
        sa_vld = 1'b1;
        #1;
        chk("t2_vld",     64'(o_req_vld),      64'b0100);
        sa_vld = 1'b0;
        req = '0;
        idle(3);

        // owner drop coinciding with another rise; non-owner start is blocked
        req = 4'b0010;
        wait_gnt(idx);
        req_start = 4'b0001;
        #1;
        chk("t4_blocked", 64'(o_sa_start), 64'd0);
        req = 4'b1000;
        cyc();
        req_start = 4'b0000;
        chk("t4_rel_gnt",    64'(o_gnt),       64'd0);
        chk("t4_rel_clearn", 64'(o_sa_clearn), 64'd0);
        req_start = 4'b0001;
        cyc();
        chk("t4_idle_gnt", 64'(o_gnt), 64'd0);
        req_start = 4'b0000;
        cyc();
        chk("t4_gnt", 64'(o_gnt), 64'b1000);
        req = '0;
        idle(3);

        // reset during a grant clears the grant and the rotation pointer
        req = 4'b0010;
        wait_gnt(idx);
        req = '0;
        idle(3);
        req = 4'b0100;
        wait_gnt(idx);
        cyc();
        rstn = 1'b0;
        req = 4'b0101;
        cyc();
        chk("t5_rst_gnt",  64'(o_gnt),  64'd0);
        chk("t5_rst_busy", 64'(o_busy), 64'd0);
        rstn = 1'b1;
        cyc();
        chk("t5_gnt", 64'(o_gnt), 64'b0001);
        req = '0;
        idle(3);

`ifdef SA_ARB_TIMEOUT_EN
        req = 4'b0011;
        wait_gnt(idx);
        n = 0;
        while (!o_timeout && n < 40) begin
            cyc();
            n++;
        end
        chk("t6_tout_cycles", 64'(n), 64'd16);
        chk("t6_tout_gnt",    64'(o_gnt), 64'd0);
        idle(2);
        chk("t6_next_gnt", 64'(o_gnt), 64'd1 << (idx ^ 1));
        req = '0;
        idle(3);
`endif

        // randomized traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            cyc();
            rstn = ($urandom_range(0, 299) != 0);
            for (int b = 0; b < N_REQ; b++) begin
                if ($urandom_range(0, 9) == 0) req[b] = ~req[b];
            end
            sa_vld     = ($urandom_range(0, 3) == 0);
            req_start  = N_REQ'($urandom);
            req_clearn = N_REQ'($urandom) | N_REQ'($urandom);
            rand_mats();
        end
        rstn = 1'b1;
        req = '0;
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
